booth_sequencer: RTL and testbench

- Control and step datapath for the radix-2 sequential Booth multiplier; sits directly upstream of the partial-product register.
- Accepts operand pairs over a valid/ready handshake.
- Drives the register's load and enable strobes and its multiplier-operand input.
- Computes the next partial product (add/subtract multiplicand, then arithmetic shift right) from the register's current output, and presents the final product over a valid/ready handshake.

---
 rtl/booth_sequencer_if.sv | 14 +
 rtl/booth_sequencer.sv | 71 +++++++
 tb/tb_booth_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/booth_sequencer_if.sv
// booth_sequencer_if: operand-accept and product-return handshakes of the Booth sequencer
interface booth_sequencer_if #(parameter int Width_in = 16);
  logic                    start_valid;
  logic                    start_ready;
  logic [Width_in-1:0]     in_A;
  logic [Width_in-1:0]     in_B;
  logic [2*Width_in-1:0]   product;
  logic                    product_valid;
  logic                    product_ready;
  modport master(output start_valid, in_A, in_B, product_ready,
                 input  start_ready, product, product_valid);
  modport slave (input  start_valid, in_A, in_B, product_ready,
                 output start_ready, product, product_valid);
endinterface

// File: rtl/booth_sequencer.sv
// booth_sequencer: control and add/sub + arithmetic-shift step for a radix-2 sequential Booth multiplier
module booth_sequencer #(
  parameter int Width_in = 16,
  parameter int Width_PP = 2*Width_in+1,
  parameter int Cnt_W    = $clog2(Width_in)
) (
  input  logic                clk,
  input  logic                reset,
  booth_sequencer_if.slave    bus,
  input  logic [Width_PP-1:0] pp_in,
  output logic [Width_PP-1:0] pp_next,
  output logic [Width_in-1:0] b_out,
  output logic                ld,
  output logic                en
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic [Width_in-1:0]   a_q, a_d, b_q, b_d;
  logic [Cnt_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            q;
  logic signed [Width_in:0] u_x, a_x, s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.start_valid) begin
        state_d = LOAD;
        a_d     = bus.in_A;
        b_d     = bus.in_B;
        cnt_d   = '0;
      end
      LOAD: state_d = RUN;
      RUN: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == Cnt_W'(Width_in-1) ? DONE : RUN;
      end
      DONE: state_d = bus.product_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // One extra bit on U and A keeps U-A exact even for A = -2^(Width_in-1)
  always_comb begin
    q       = pp_in[1:0];
    u_x     = {pp_in[Width_PP-1], pp_in[Width_PP-1:Width_in+1]};
    a_x     = {a_q[Width_in-1], a_q};
    s       = q == 2'b01 ? u_x + a_x : q == 2'b10 ? u_x - a_x : u_x;
    pp_next = {s, pp_in[Width_in:1]};
  end
  always_comb begin
    bus.start_ready   = reset && state_q == IDLE;
    ld                = state_q == LOAD;
    en                = state_q == RUN;
    bus.product_valid = state_q == DONE;
    bus.product       = state_q == DONE ? pp_in[Width_PP-1:1] : '0;
    b_out             = b_q;
  end
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: directed and random checks of the Booth sequencer against a latency/product model
module tb_booth_sequencer;
  localparam int W = 16;
  logic clk = 0;
  logic reset = 1;
  logic [2*W:0] pp_q = '0;
  logic [2*W:0] pp_next;
  logic [W-1:0] b_out;
  logic ld, en;
  int n_cmp = 0;
  int n_bad = 0;
  bit busy = 0;
  int age = 0;
  logic [W-1:0]   m_b = '0;
  logic [2*W-1:0] m_prod = '0;
  booth_sequencer_if #(.Width_in(W)) bus();
  booth_sequencer #(.Width_in(W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pp_in(pp_q), .pp_next(pp_next),
    .b_out(b_out), .ld(ld), .en(en));
  always #5 clk = ~clk;
  // Downstream partial-product register
  always @(posedge clk)
    if (ld) pp_q <= {{W{1'b0}}, b_out, 1'b0};
    else if (en) pp_q <= pp_next;
  function automatic logic [2*W-1:0] mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = a;
    y = b;
    return x * y;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: accept when idle; ld one cycle later, W en cycles, then valid until taken
  always @(posedge clk or negedge reset)
    if (!reset) begin
      busy <= 0;
      age  <= 0;
      m_b  <= '0;
    end else if (!busy) begin
      if (bus.start_valid) begin
        busy   <= 1;
        age    <= 1;
        m_b    <= bus.in_B;
        m_prod <= mul(bus.in_A, bus.in_B);
      end
    end else if (age >= W+2) begin
      if (bus.product_ready) begin
        busy <= 0;
        age  <= 0;
      end
    end else age <= age + 1;
  always @(negedge clk) begin
    chk("start_ready", bus.start_ready, reset && !busy);
    chk("ld", ld, busy && age == 1);
    chk("en", en, busy && age >= 2 && age <= W+1);
    chk("product_valid", bus.product_valid, busy && age >= W+2);
    chk("product", bus.product, (busy && age >= W+2) ? m_prod : 32'd0);
    chk("b_out", b_out, m_b);
    chk("ld_en_excl", ld && en, 1'b0);
  end
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] lit, input int stall);
    int t;
    bus.product_ready = (stall == 0);
    bus.start_valid = 1;
    bus.in_A = a;
    bus.in_B = b;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.start_ready && t < 50);
    if (!bus.start_ready) begin
      chk("accept_timeout", bus.start_ready, 1);
      bus.start_valid = 0;
      return;
    end
    @(posedge clk); #1;
    bus.start_valid = 0;
    bus.in_A = ~a;
    bus.in_B = ~b;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.product_valid && t < 100);
    chk("latency", t, W+2);
    chk("product_lit", bus.product, lit);
    if (stall > 0) begin
      bus.start_valid = 1;
      bus.in_A = 16'h7777;
      bus.in_B = 16'h0101;
      repeat (stall) @(negedge clk);
      chk("bp_product", bus.product, lit);
      chk("bp_valid", bus.product_valid, 1);
      chk("bp_ready", bus.start_ready, 0);
      bus.product_ready = 1;
      bus.start_valid = 0;
    end
    @(posedge clk); #1;
    bus.product_ready = 0;
  endtask
  initial begin
    bus.start_valid = 0;
    bus.in_A = '0;
    bus.in_B = '0;
    bus.product_ready = 0;
    #1 reset = 0;
    #3;
    chk("rst_ld", ld, 0);
    chk("rst_en", en, 0);
    chk("rst_valid", bus.product_valid, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_ready", bus.start_ready, 0);
    @(negedge clk); #2 reset = 1;
    @(negedge clk);
    chk("idle_ready", bus.start_ready, 1);
    do_op(16'd3, 16'd5, 32'h0000000F, 0);
    do_op(-16'sd7, 16'd6, 32'hFFFFFFD6, 0);
    do_op(16'd6, -16'sd7, 32'hFFFFFFD6, 0);
    do_op(16'h8000, 16'h8000, 32'h40000000, 0);
    do_op(16'h8000, 16'h7FFF, 32'hC0008000, 0);
    do_op(16'h0000, 16'h1234, 32'h00000000, 0);
    do_op(16'd3, 16'd5, 32'h0000000F, 5);
    @(negedge clk);
    chk("bp_idle_ready", bus.start_ready, 1);
    // Abort while the step counter sits at 7
    bus.start_valid = 1;
    bus.in_A = 16'd100;
    bus.in_B = 16'd100;
    @(posedge clk); #1;
    bus.start_valid = 0;
    repeat (9) @(negedge clk);
    chk("mid_en", en, 1);
    #1 reset = 0;
    #1;
    chk("abort_ld", ld, 0);
    chk("abort_en", en, 0);
    chk("abort_valid", bus.product_valid, 0);
    chk("abort_ready", bus.start_ready, 0);
    @(negedge clk); #2 reset = 1;
    do_op(16'd2, 16'd9, 32'd18, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, mul(ra, rb), int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
